// File: rtl/imem_pkg.sv
// imem_pkg: shared types, constants and helpers for the instruction-memory port arbiter
package imem_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        DRAIN   = 2'd2,
        RESTART = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        FETCH  = 2'd1,
        LOADER = 2'd2
    } owner_t;

    localparam logic [31:0] BOOT_ADDR_DEF = 32'h0000_0000;

    function automatic logic [29:0] WORD_ADDR(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/imem_rr_pick.sv
// imem_rr_pick: two-way fetch/loader picker, fixed loader priority or round-robin on rr_last
module imem_rr_pick
    import imem_pkg::*;
#(
    parameter bit LOADER_PRIO = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_f,
    input  logic i_req_l,
    output logic o_gnt_f,
    output logic o_gnt_l
);

    owner_t r_rr_last;
    logic   w_both;

    always_comb begin
        w_both  = i_req_f & i_req_l;
        o_gnt_l = i_req_l & (!i_req_f | LOADER_PRIO | (r_rr_last == FETCH));
        o_gnt_f = i_req_f & !o_gnt_l;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rr_last <= LOADER;
        else if (w_both)
            r_rr_last <= o_gnt_l ? LOADER : FETCH;
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the instruction memory between fetch and the loader, sequencing load sessions
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int          SIZE        = 1024,
    parameter logic [31:0] BOOT_ADDR   = BOOT_ADDR_DEF,
    parameter bit          LOADER_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_f_req,
    input  logic [31:0] i_f_addr,
    output logic        o_f_gnt,
    output logic        o_f_rvalid,
    output logic [31:0] o_f_rdata,
    output logic [31:0] o_f_rdata_pred,
    output logic        o_f_fault,
    output logic        o_f_stall,
    output logic        o_f_restart,
    output logic [31:0] o_f_restart_pc,
    input  logic        i_l_session,
    input  logic        i_l_req,
    input  logic        i_l_we,
    input  logic [31:0] i_l_addr,
    input  logic [31:0] i_l_wdata,
    input  logic [3:0]  i_l_mask,
    output logic        o_l_gnt,
    output logic        o_l_rvalid,
    output logic [31:0] o_l_rdata,
    output logic        o_l_err,
    output logic [31:0] o_m_addr,
    output logic        o_m_ren,
    output logic        o_m_we,
    output logic [3:0]  o_m_wmask,
    output logic [31:0] o_m_wdata,
    input  logic [31:0] i_m_rdata,
    input  logic [31:0] i_m_rdata_pred
);

    localparam logic [31:0] W_SIZE = 32'(SIZE);

    state_t      r_state;
    state_t      w_next;
    owner_t      r_owner;
    logic        r_fault;
    logic        r_l_rd;
    logic [31:0] r_f_rdata;
    logic [31:0] r_f_rdata_pred;
    logic [31:0] r_l_rdata;
    logic        w_f_req;
    logic        w_l_req;
    logic        w_f_oor;
    logic        w_l_oor;
    logic        w_l_err;
    logic        w_l_rd_rsp;

    always_comb begin
        w_f_req = i_f_req & (r_state == RUN);
        w_l_req = i_l_req & (r_state != DRAIN);
    end

    imem_rr_pick #(
        .LOADER_PRIO(LOADER_PRIO)
    ) u_pick (
        .clk     (clk),
        .rst     (rst),
        .i_req_f (w_f_req),
        .i_req_l (w_l_req),
        .o_gnt_f (o_f_gnt),
        .o_gnt_l (o_l_gnt)
    );

    always_comb begin
        w_next         = r_state;
        o_f_stall      = (r_state == LOAD) | (r_state == DRAIN);
        o_f_restart    = r_state == RESTART;
        o_f_restart_pc = BOOT_ADDR;
        case (r_state)
            RUN:     w_next = i_l_session ? LOAD : RUN;
            LOAD:    w_next = i_l_session ? LOAD : DRAIN;
            DRAIN:   w_next = RESTART;
            RESTART: w_next = i_l_session ? LOAD : RUN;
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_next;
    end

    // writes are only legal while a session owns the memory
    always_comb begin
        w_f_oor   = {2'b00, WORD_ADDR(i_f_addr)} >= W_SIZE;
        w_l_oor   = {2'b00, WORD_ADDR(i_l_addr)} >= W_SIZE;
        w_l_err   = w_l_oor | (i_l_we & (r_state != LOAD));
        o_m_addr  = o_f_gnt ? i_f_addr : (o_l_gnt ? i_l_addr : '0);
        o_m_ren   = (o_f_gnt & !w_f_oor) | (o_l_gnt & !i_l_we & !w_l_oor);
        o_m_we    = o_l_gnt & i_l_we & !w_l_err;
        o_m_wmask = o_m_we ? i_l_mask : '0;
        o_m_wdata = o_m_we ? i_l_wdata : '0;
    end

    always_comb begin
        o_f_rvalid     = r_owner == FETCH;
        o_f_fault      = o_f_rvalid & r_fault;
        o_f_rdata      = o_f_rvalid ? (r_fault ? '0 : i_m_rdata) : r_f_rdata;
        o_f_rdata_pred = o_f_rvalid ? (r_fault ? '0 : i_m_rdata_pred) : r_f_rdata_pred;
        o_l_rvalid     = r_owner == LOADER;
        o_l_err        = o_l_rvalid & r_fault;
        w_l_rd_rsp     = o_l_rvalid & r_l_rd;
        o_l_rdata      = w_l_rd_rsp ? (r_fault ? '0 : i_m_rdata) : r_l_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner        <= NONE;
            r_fault        <= 1'b0;
            r_l_rd         <= 1'b0;
            r_f_rdata      <= '0;
            r_f_rdata_pred <= '0;
            r_l_rdata      <= '0;
        end else begin
            r_owner        <= o_f_gnt ? FETCH : (o_l_gnt ? LOADER : NONE);
            r_fault        <= o_f_gnt ? w_f_oor : w_l_err;
            r_l_rd         <= !i_l_we;
            r_f_rdata      <= o_f_rdata;
            r_f_rdata_pred <= o_f_rdata_pred;
            r_l_rdata      <= o_l_rdata;
        end
    end

endmodule
